// File: rtl/aes_key_schedule_rev.sv
// aes_key_schedule_rev: streams AES-128 round keys 10 down to 0 from one cipher key.
// Define AES_EQINV_KEY_EN to emit InvMixColumns(round key) for rounds 1..9.
module aes_key_schedule_rev (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         key_valid,
   output logic         key_ready,
   input  logic [127:0] key_in,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic [127:0] rk_out,
   output logic [3:0]   rk_round,
   output logic         rk_last,
   output logic         busy
);
   typedef enum logic [1:0] {IDLE, FWD, OUT} state_t;
   state_t state, state_nx;
   logic [127:0] key, key_nx;
   logic [3:0] rnd, rnd_nx;
   logic [31:0] w0, w1, w2, w3, sw_in, rot, sub, t, f0, f1, f2, f3, p0, p1, p2, p3;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         p = b[i] ? p ^ x : p;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // multiplicative inverse as x^254, then the affine map
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] x2, x3, x6, x12, y, b;
      x2 = gmul(x, x);
      x3 = gmul(x2, x);
      x6 = gmul(x3, x3);
      x12 = gmul(x6, x6);
      y = gmul(x12, x3);
      for (int i = 0; i < 4; i++) y = gmul(y, y);
      b = gmul(gmul(y, x12), x2);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] r);
      return (r == 4'd9) ? 8'h1b : (r == 4'd10) ? 8'h36 :
             (r >= 4'd1 && r <= 4'd8) ? 8'h01 << (r - 4'd1) : 8'h00;
   endfunction

   assign {w0, w1, w2, w3} = key;
   assign p3 = w3 ^ w2;
   assign p2 = w2 ^ w1;
   assign p1 = w1 ^ w0;
   // single S-box path: forward uses w3, reverse uses the recovered w3 of round r-1
   assign sw_in = (state == OUT) ? p3 : w3;
   assign rot = {sw_in[23:0], sw_in[31:24]};
   assign sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
   assign t = sub ^ {rcon(rnd), 24'h0};
   assign f0 = w0 ^ t;
   assign f1 = w1 ^ f0;
   assign f2 = w2 ^ f1;
   assign f3 = w3 ^ f2;
   assign p0 = w0 ^ t;

   always_comb begin
      state_nx = state;
      key_nx = key;
      rnd_nx = rnd;
      case (state)
         IDLE: if (key_valid) begin
            state_nx = FWD;
            key_nx = key_in;
            rnd_nx = 4'd1;
         end
         FWD: begin
            key_nx = {f0, f1, f2, f3};
            if (rnd == 4'd10) state_nx = OUT;
            else rnd_nx = rnd + 4'd1;
         end
         OUT: if (rk_ready) begin
            if (rnd == 4'd0) state_nx = IDLE;
            else begin
               key_nx = {p0, p1, p2, p3};
               rnd_nx = rnd - 4'd1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         key <= '0;
         rnd <= '0;
      end else begin
         state <= state_nx;
         key <= key_nx;
         rnd <= rnd_nx;
      end
   end

   assign key_ready = state == IDLE;
   assign rk_valid = state == OUT;
   assign busy = state != IDLE;
   assign rk_round = rnd;
   assign rk_last = (state == OUT) && (rnd == 4'd0);

`ifdef AES_EQINV_KEY_EN
   function automatic logic [31:0] imc_col(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = c;
      return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
              gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
              gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
              gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
   endfunction

   assign rk_out = (rnd != 4'd0 && rnd != 4'd10) ?
                   {imc_col(w0), imc_col(w1), imc_col(w2), imc_col(w3)} : key;
`else
   assign rk_out = key;
`endif
endmodule
